// File: rtl/cf_gpio_in_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : cf_gpio_in_conditioner
// Description : Pad input receive path: synchroniser, debounce, edge detect,
//               sticky interrupt flag. One instance per pad.
// Revision    : 1.0 - initial release
// ============================================================================
module cf_gpio_in_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gpio_in,
  input  logic                db_en,
  input  logic [DB_CNT_W-1:0] db_limit,
  input  logic [1:0]          edge_sel,
  input  logic                irq_clr,
  output logic                io_in,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                irq
);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_QUALIFY = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [0:0]             state;
  logic [DB_CNT_W-1:0]    cnt;
  logic [DB_CNT_W-1:0]    eff_limit;
  logic [DB_CNT_W:0]      cnt_inc;
  logic                   differ;
  logic                   commit;
  logic                   irq_set;

  // Plain shift chain: nothing may sit between the synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    eff_limit = db_limit;
    if (!db_en || (db_limit == '0)) begin
      eff_limit = DB_CNT_W'(1);
    end
  end

  // One extra bit keeps cnt+1 from wrapping in the compare; >= lets a lowered
  // limit commit on the very next edge.
  assign cnt_inc = {1'b0, cnt} + (DB_CNT_W+1)'(1);
  assign differ  = (synced != stable);
  assign commit  = differ && (cnt_inc >= {1'b0, eff_limit});
  assign irq_set = (rise_pulse & edge_sel[0]) | (fall_pulse & edge_sel[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable     <= RESET_VAL;
      cnt        <= '0;
      state      <= ST_STABLE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rise_pulse <= commit & synced;
      fall_pulse <= commit & ~synced;
      irq        <= irq_set | (irq & ~irq_clr);

      case (state)
        ST_STABLE: begin
          if (commit) begin
            stable <= synced;
            cnt    <= '0;
          end else if (differ) begin
            cnt   <= cnt_inc[DB_CNT_W-1:0];
            state <= ST_QUALIFY;
          end else begin
            cnt <= '0;
          end
        end
        ST_QUALIFY: begin
          if (commit) begin
            stable <= synced;
            cnt    <= '0;
            state  <= ST_STABLE;
          end else if (differ) begin
            cnt <= cnt_inc[DB_CNT_W-1:0];
          end else begin
            cnt   <= '0;
            state <= ST_STABLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_STABLE;
        end
      endcase
    end
  end

  assign io_in = stable;

endmodule
`default_nettype wire

// File: tb/tb_cf_gpio_in_conditioner.sv
`default_nettype none
// Scoreboard bench for cf_gpio_in_conditioner: stimulus pushes cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_cf_gpio_in_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gpio_in;
  logic        db_en;
  logic [15:0] db_limit;
  logic [1:0]  edge_sel;
  logic        irq_clr;
  logic        io_in;
  logic        rise_pulse;
  logic        fall_pulse;
  logic        irq;

  cf_gpio_in_conditioner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_in    (gpio_in),
    .db_en      (db_en),
    .db_limit   (db_limit),
    .edge_sel   (edge_sel),
    .irq_clr    (irq_clr),
    .io_in      (io_in),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit io;
    bit rp;
    bit fp;
    bit iq;
    int step;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   step   = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL step%0d cyc%0d: vector never checked (now cyc%0d)", e.step, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_vec++;
      if ({io_in, rise_pulse, fall_pulse, irq} !== {e.io, e.rp, e.fp, e.iq}) begin
        n_bad++;
        $display("FAIL step%0d cyc%0d: {io_in,rise,fall,irq} got %b%b%b%b want %b%b%b%b",
                 e.step, e.cyc, io_in, rise_pulse, fall_pulse, irq, e.io, e.rp, e.fp, e.iq);
      end
    end
  end

  task automatic push(input int dc, input bit io, input bit rp, input bit fp, input bit iq);
    exp_t e;
    e.cyc = cyc + dc; e.io = io; e.rp = rp; e.fp = fp; e.iq = iq; e.step = step;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_irq(input bit io);
    irq_clr = 1'b1;
    push(1, io, 0, 0, 0);
    tick(1);
    irq_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; gpio_in = 1'b1; db_en = 1'b0; db_limit = 16'd0;
    edge_sel = 2'b01; irq_clr = 1'b0;

    // Reset with pad high, release: rises on third edge, irq follows
    step = 0;
    tick(3);
    push(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0);
    push(3, 1, 1, 0, 0); push(4, 1, 0, 0, 1);
    tick(5);
    clr_irq(1);

    // Fall irq with simultaneous clear: set wins, clear next cycle
    step = 1;
    edge_sel = 2'b10; gpio_in = 1'b0;
    push(2, 1, 0, 0, 0); push(3, 0, 0, 1, 0);
    push(4, 0, 0, 0, 1); push(5, 0, 0, 0, 0);
    tick(3); irq_clr = 1'b1;
    tick(2); irq_clr = 1'b0;

    // L=4, 3-cycle high glitch is filtered
    step = 2;
    edge_sel = 2'b01; db_en = 1'b1; db_limit = 16'd4; gpio_in = 1'b1;
    push(3, 0, 0, 0, 0); push(5, 0, 0, 0, 0); push(7, 0, 0, 0, 0);
    tick(3); gpio_in = 1'b0;
    tick(5);

    // L=4, sustained high commits after 6 edges, then sustained low
    step = 3;
    gpio_in = 1'b1;
    push(5, 0, 0, 0, 0); push(6, 1, 1, 0, 0); push(7, 1, 0, 0, 1);
    tick(10);
    gpio_in = 1'b0;
    push(5, 1, 0, 0, 1); push(6, 0, 0, 1, 1); push(7, 0, 0, 0, 1);
    tick(8);
    clr_irq(0);

    // Limit lowered from 100 to 20 with cnt=50: commit on next edge
    step = 4;
    db_limit = 16'd100; gpio_in = 1'b1;
    push(52, 0, 0, 0, 0); push(53, 1, 1, 0, 0); push(54, 1, 0, 0, 1);
    tick(52); db_limit = 16'd20;
    tick(3);
    clr_irq(1);

    // db_limit=0 with db_en=1 behaves as bypass
    step = 5;
    db_limit = 16'd0; edge_sel = 2'b10; gpio_in = 1'b0;
    push(2, 1, 0, 0, 0); push(3, 0, 0, 1, 0); push(4, 0, 0, 0, 1);
    tick(5);
    clr_irq(0);

    // db_en=0 ignores a nonzero limit: 3-edge latency
    step = 6;
    db_en = 1'b0; db_limit = 16'd4; edge_sel = 2'b01; gpio_in = 1'b1;
    push(2, 0, 0, 0, 0); push(3, 1, 1, 0, 0); push(4, 1, 0, 0, 1);
    tick(5);
    clr_irq(1);

    // Back-to-back toggles in bypass: a pulse on every commit, no irq
    step = 7;
    edge_sel = 2'b00; gpio_in = 1'b0;
    push(3, 0, 0, 1, 0); push(4, 1, 1, 0, 0); push(5, 0, 0, 1, 0);
    push(6, 1, 1, 0, 0); push(7, 1, 0, 0, 0);
    tick(1); gpio_in = 1'b1;
    tick(1); gpio_in = 1'b0;
    tick(1); gpio_in = 1'b1;
    tick(5);

    // Reset at cnt=3 of 4: immediate reset, no pulse, count restarts
    step = 8;
    db_en = 1'b1; db_limit = 16'd4; edge_sel = 2'b01; gpio_in = 1'b0;
    tick(5);
    rst_n = 1'b0;
    push(0, 0, 0, 0, 0); push(1, 0, 0, 0, 0);
    tick(2);
    gpio_in = 1'b1; rst_n = 1'b1;
    push(5, 0, 0, 0, 0); push(6, 1, 1, 0, 0); push(7, 1, 0, 0, 1);
    tick(9);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
